rx_frame_parser: RTL and testbench
==================================

RX_FRAME_PARSER -- requirements
Module: rx_frame_parser

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width of input and output streams.
REQ-002 SHALL have parameter MAX_LEN, default 16, max payload words per frame; legal range 1 <= MAX_LEN < 2**DATA_WIDTH.
REQ-003 SHALL have parameter SOF_WORD, default 8'hA5 (DATA_WIDTH bits), start-of-frame delimiter.
REQ-004 SHALL use one clock and synchronous active-high reset, named clk_i and rst_i.
REQ-005 Ports, in this order:
 clk_i  in  1  clock, all logic on rising edge
 rst_i  in  1  synchronous active-high reset
 data_in_i  in  DATA_WIDTH  word from deserializer parallel output
 valid_in_i  in  1  data_in_i qualifier; no backpressure exists upstream
 m_data_o  out  DATA_WIDTH  payload word
 m_valid_o  out  1  m_data_o valid
 m_ready_i  in  1  downstream accept
 m_last_o  out  1  final payload word of frame
 frame_ok_o  out  1  one-cycle pulse, checksum pass
 frame_err_o  out  1  one-cycle pulse, bad length or checksum
 drop_cnt_o  out  8  saturating count of input words discarded during DRAIN

Function
REQ-006 Frame format SHALL be: SOF_WORD, LEN, LEN payload words, CHK, where CHK = XOR of LEN and all payload words.
REQ-007 FSM states SHALL be IDLE, LEN, PAYLOAD, CHK, DRAIN; only cycles with valid_in_i=1 advance IDLE..CHK.
REQ-008 IDLE: valid word equal to SOF_WORD -> LEN; any other valid word ignored, not counted.
REQ-009 LEN: valid word, unsigned, equal to 0 or > MAX_LEN -> frame_err_o pulse next cycle, -> IDLE; else store LEN, init checksum = LEN, clear write index, -> PAYLOAD.
REQ-010 PAYLOAD: each valid word written to buf[wr_idx], checksum ^= word, wr_idx++; after word LEN-1 written -> CHK.
REQ-011 A SOF_WORD value inside LEN, PAYLOAD or CHK SHALL be treated as data, not resync.
REQ-012 CHK: valid word equal to checksum -> frame_ok_o pulse, -> DRAIN; mismatch -> frame_err_o pulse, -> IDLE, buffer discarded.
REQ-013 frame_ok_o/frame_err_o SHALL be registered, asserted exactly the cycle after the deciding word is sampled.
REQ-014 DRAIN: m_valid_o=1 from the cycle after CHK accepted (first-word latency 1 cycle); m_data_o = buf[rd_idx]; m_last_o = (rd_idx == LEN-1).
REQ-015 m_data_o, m_last_o SHALL hold stable while m_valid_o=1 and m_ready_i=0.
REQ-016 On m_valid_o & m_ready_i: rd_idx++; on handshake with m_last_o=1 -> IDLE next cycle, m_valid_o=0.
REQ-017 Outside DRAIN m_valid_o and m_last_o SHALL be 0.
REQ-018 Any valid_in_i=1 in DRAIN SHALL increment drop_cnt_o, saturating at 255; word not parsed.
REQ-019 Input on the cycle of the final drain handshake SHALL count as dropped; IDLE parsing resumes the following cycle.
REQ-020 Buffer SHALL hold MAX_LEN words; index registers width $clog2(MAX_LEN+1); no wrap occurs since LEN <= MAX_LEN.

Reset
REQ-021 rst_i=1 on any edge SHALL force IDLE, clear indices, checksum, stored LEN, drop_cnt_o=0, m_valid_o=0, m_last_o=0, frame_ok_o=0, frame_err_o=0; buffer contents need not be cleared.
REQ-022 Reset mid-frame or mid-drain SHALL abandon the frame with no frame_ok_o/frame_err_o pulse.

Verification
REQ-023 Good frame: A5,03,11,22,33,CHK=03^11^22^33=03, m_ready_i=1 -> frame_ok_o pulse, outputs 11,22,33 on consecutive cycles, m_last_o with 33.
REQ-024 Bad checksum: A5,02,10,20,FF -> frame_err_o pulse, m_valid_o stays 0, next frame A5,01,7E,7F parses OK.
REQ-025 Bad length: A5,00 and A5,11 (MAX_LEN=16) -> frame_err_o each, return IDLE, no output.
REQ-026 Backpressure: good 3-word frame, m_ready_i toggled 0/1 -> data held stable, all 3 words delivered in order, last flagged once.
REQ-027 Drop/saturate: m_ready_i=0 in DRAIN, 300 valid input words -> drop_cnt_o=255; release ready -> frame completes, IDLE.
REQ-028 Reset mid-PAYLOAD: A5,04,01,02 then rst_i 1 cycle -> all outputs 0, drop_cnt_o=0, following good frame parses correctly.

Source files
------------

// File: rtl/rx_frame_parser.sv
// rx_frame_parser: recovers framed payloads from a deserializer word stream.
// Frame layout is SOF, LEN, LEN payload words, CHK where CHK is the XOR of LEN
// and every payload word. A frame whose checksum matches is buffered and then
// replayed on a valid/ready output stream. Words arriving while the buffer is
// being drained cannot be parsed (upstream has no backpressure) and are
// counted instead.
module rx_frame_parser #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    MAX_LEN    = 16,
    parameter logic [DATA_WIDTH-1:0] SOF_WORD   = DATA_WIDTH'(8'hA5)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] data_in_i,
    input  logic                  valid_in_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic                  m_last_o,
    output logic                  frame_ok_o,
    output logic                  frame_err_o,
    output logic [7:0]            drop_cnt_o
);

    localparam int                    IDX_W     = $clog2(MAX_LEN + 1);
    localparam logic [IDX_W-1:0]      ONE_IDX   = IDX_W'(1);
    localparam logic [DATA_WIDTH-1:0] MAX_LEN_W = DATA_WIDTH'(MAX_LEN);
    localparam logic [DATA_WIDTH-1:0] ZERO_W    = DATA_WIDTH'(0);
    localparam logic [7:0]            DROP_MAX  = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    // Running checksum step: the frame check word is a plain XOR fold.
    function automatic logic [DATA_WIDTH-1:0] chk_fold(
        input logic [DATA_WIDTH-1:0] acc,
        input logic [DATA_WIDTH-1:0] word
    );
        return acc ^ word;
    endfunction

    state_t                state_r;
    state_t                state_n_s;
    logic [IDX_W-1:0]      len_r;
    logic [IDX_W-1:0]      wr_idx_r;
    logic [IDX_W-1:0]      rd_idx_r;
    logic [DATA_WIDTH-1:0] chk_r;
    logic [DATA_WIDTH-1:0] buf_r [MAX_LEN];
    logic [DATA_WIDTH-1:0] m_data_r;
    logic                  m_valid_r;
    logic                  m_last_r;
    logic                  frame_ok_r;
    logic                  frame_err_r;
    logic [7:0]            drop_cnt_r;

    logic                  ok_s;
    logic                  err_s;
    logic                  len_load_s;
    logic                  pay_wr_s;
    logic                  drop_s;
    logic                  hs_s;
    logic [IDX_W-1:0]      len_last_s;
    logic [IDX_W-1:0]      rd_next_s;
    logic [DATA_WIDTH-1:0] buf_next_s;

    // Buffer read-ahead: the word that follows the one currently presented.
    always_comb begin
        len_last_s = len_r - ONE_IDX;
        rd_next_s  = rd_idx_r + ONE_IDX;
        buf_next_s = ZERO_W;
        for (int i = 0; i < MAX_LEN; i++) begin
            buf_next_s = (rd_next_s == IDX_W'(i)) ? buf_r[i] : buf_next_s;
        end
    end

    // Parser next-state and per-cycle control strobes.
    always_comb begin
        state_n_s  = state_r;
        ok_s       = 1'b0;
        err_s      = 1'b0;
        len_load_s = 1'b0;
        pay_wr_s   = 1'b0;
        drop_s     = 1'b0;
        hs_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (valid_in_i && (data_in_i == SOF_WORD)) begin
                    state_n_s = ST_LEN;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_LEN: begin
                if (valid_in_i) begin
                    if ((data_in_i == ZERO_W) || (data_in_i > MAX_LEN_W)) begin
                        err_s     = 1'b1;
                        state_n_s = ST_IDLE;
                    end else begin
                        len_load_s = 1'b1;
                        state_n_s  = ST_PAYLOAD;
                    end
                end else begin
                    state_n_s = ST_LEN;
                end
            end
            ST_PAYLOAD: begin
                if (valid_in_i) begin
                    pay_wr_s = 1'b1;
                    if (wr_idx_r == len_last_s) begin
                        state_n_s = ST_CHK;
                    end else begin
                        state_n_s = ST_PAYLOAD;
                    end
                end else begin
                    state_n_s = ST_PAYLOAD;
                end
            end
            ST_CHK: begin
                if (valid_in_i) begin
                    if (data_in_i == chk_r) begin
                        ok_s      = 1'b1;
                        state_n_s = ST_DRAIN;
                    end else begin
                        err_s     = 1'b1;
                        state_n_s = ST_IDLE;
                    end
                end else begin
                    state_n_s = ST_CHK;
                end
            end
            ST_DRAIN: begin
                drop_s = valid_in_i;
                if (m_valid_r && m_ready_i) begin
                    hs_s = 1'b1;
                    if (m_last_r) begin
                        state_n_s = ST_IDLE;
                    end else begin
                        state_n_s = ST_DRAIN;
                    end
                end else begin
                    state_n_s = ST_DRAIN;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Frame capture: stored length, write index and running checksum.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            len_r    <= '0;
            wr_idx_r <= '0;
            chk_r    <= ZERO_W;
        end else if (len_load_s) begin
            len_r    <= data_in_i[IDX_W-1:0];
            wr_idx_r <= '0;
            chk_r    <= data_in_i;
        end else if (pay_wr_s) begin
            wr_idx_r <= wr_idx_r + ONE_IDX;
            chk_r    <= chk_fold(chk_r, data_in_i);
        end else begin
            len_r    <= len_r;
            wr_idx_r <= wr_idx_r;
            chk_r    <= chk_r;
        end
    end

    // Payload buffer; contents are only meaningful once a frame has checked good.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < MAX_LEN; i++) begin
            if (pay_wr_s && (wr_idx_r == IDX_W'(i))) begin
                buf_r[i] <= data_in_i;
            end
        end
    end

    // Output stream: load the first word on a good check, advance on handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_idx_r  <= '0;
            m_data_r  <= ZERO_W;
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
        end else if (ok_s) begin
            rd_idx_r  <= '0;
            m_data_r  <= buf_r[0];
            m_valid_r <= 1'b1;
            m_last_r  <= (len_r == ONE_IDX);
        end else if (hs_s) begin
            if (m_last_r) begin
                m_valid_r <= 1'b0;
                m_last_r  <= 1'b0;
            end else begin
                rd_idx_r <= rd_next_s;
                m_data_r <= buf_next_s;
                m_last_r <= (rd_next_s == len_last_s);
            end
        end else begin
            rd_idx_r <= rd_idx_r;
        end
    end

    // Status pulses, one cycle after the deciding word, and saturating drop count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_ok_r  <= 1'b0;
            frame_err_r <= 1'b0;
            drop_cnt_r  <= 8'h00;
        end else begin
            frame_ok_r  <= ok_s;
            frame_err_r <= err_s;
            if (drop_s && (drop_cnt_r != DROP_MAX)) begin
                drop_cnt_r <= drop_cnt_r + 8'h01;
            end
        end
    end

    assign m_data_o    = m_data_r;
    assign m_valid_o   = m_valid_r;
    assign m_last_o    = m_last_r;
    assign frame_ok_o  = frame_ok_r;
    assign frame_err_o = frame_err_r;
    assign drop_cnt_o  = drop_cnt_r;

endmodule

// File: tb/tb_rx_frame_parser.sv
// Scoreboard bench for rx_frame_parser. The stimulus side computes each
// frame's outcome from the frame rules (length range, XOR of length and
// payload) and queues the expected status pulse and payload words; monitor
// processes pop and compare whenever the DUT presents them.
module tb_rx_frame_parser;

    localparam int         DW  = 8;
    localparam int         ML  = 16;
    localparam logic [7:0] SOF = 8'hA5;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       valid_in;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;
    logic       frame_ok;
    logic       frame_err;
    logic [7:0] drop_cnt;

    typedef struct { bit ok; int cyc; } ev_t;
    typedef struct { logic [7:0] d; bit last; } pl_t;

    ev_t ev_q[$];
    pl_t pl_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  exp_drop = 0;
    int  rdy_mode = 0;
    int  cyc      = 0;
    int  drv_cyc  = 0;
    int  last_chk_cyc = 0;

    rx_frame_parser #(.DATA_WIDTH(DW), .MAX_LEN(ML), .SOF_WORD(SOF)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .data_in_i   (data_in),
        .valid_in_i  (valid_in),
        .m_data_o    (m_data),
        .m_valid_o   (m_valid),
        .m_ready_i   (m_ready),
        .m_last_o    (m_last),
        .frame_ok_o  (frame_ok),
        .frame_err_o (frame_err),
        .drop_cnt_o  (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Downstream ready: 0 = always ready, 1 = random, other = stalled.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Monitor: output stream, hold behaviour and status pulses.
    logic       prev_v = 1'b0;
    logic       prev_r = 1'b0;
    logic       prev_l = 1'b0;
    logic       prev_rst = 1'b1;
    logic [7:0] prev_d = 8'h00;
    always @(negedge clk) begin
        if (!rst && !prev_rst) begin
            if (m_last && !m_valid) chk("last_without_valid", 32'(m_last), 32'd0);
            if (prev_v && !prev_r) begin
                chk("hold_valid", 32'(m_valid), 32'd1);
                chk("hold_data", 32'(m_data), 32'(prev_d));
                chk("hold_last", 32'(m_last), 32'(prev_l));
            end
            if (m_valid && m_ready) begin
                chk("word_expected", 32'(pl_q.size() > 0), 32'd1);
                if (pl_q.size() > 0) begin
                    pl_t e;
                    e = pl_q.pop_front();
                    chk("payload_data", 32'(m_data), 32'(e.d));
                    chk("payload_last", 32'(m_last), 32'(e.last));
                end
            end
            if (frame_ok || frame_err) begin
                chk("pulse_exclusive", 32'(frame_ok && frame_err), 32'd0);
                chk("pulse_expected", 32'(ev_q.size() > 0), 32'd1);
                if (ev_q.size() > 0) begin
                    ev_t e;
                    e = ev_q.pop_front();
                    chk("pulse_kind_ok", 32'(frame_ok), 32'(e.ok));
                    chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
                    if (frame_ok) chk("first_word_latency", 32'(m_valid), 32'd1);
                end
            end
        end
        prev_v   <= m_valid;
        prev_r   <= m_ready;
        prev_l   <= m_last;
        prev_d   <= m_data;
        prev_rst <= rst;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic send_word(input logic [7:0] w);
        @(posedge clk);
        #1;
        valid_in = 1'b1;
        data_in  = w;
        drv_cyc  = cyc;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            valid_in = 1'b0;
            data_in  = 8'($urandom);
        end
    endtask

    // Reference model: outcome follows from LEN range and XOR of LEN and payload.
    // chk_mode 0 = correct check word, 1 = one bit flipped, 2 = use chk_val.
    task automatic send_frame(input int len, input logic [7:0] pl[$], input int chk_mode,
                              input logic [7:0] chk_val, input int maxgap);
        logic [7:0] sum;
        logic [7:0] sent;
        send_word(SOF);
        gap($urandom_range(0, maxgap));
        send_word(8'(len));
        if (len == 0 || len > ML) begin
            ev_q.push_back('{ok: 1'b0, cyc: drv_cyc + 1});
            gap(1);
            return;
        end
        sum = 8'(len);
        for (int k = 0; k < len; k++) begin
            gap($urandom_range(0, maxgap));
            send_word(pl[k]);
            sum = sum ^ pl[k];
        end
        case (chk_mode)
            0:       sent = sum;
            1:       sent = sum ^ (8'h01 << $urandom_range(0, 7));
            default: sent = chk_val;
        endcase
        gap($urandom_range(0, maxgap));
        send_word(sent);
        last_chk_cyc = drv_cyc;
        if (sent == sum) begin
            ev_q.push_back('{ok: 1'b1, cyc: drv_cyc + 1});
            for (int k = 0; k < len; k++) pl_q.push_back('{d: pl[k], last: (k == len - 1)});
        end else begin
            ev_q.push_back('{ok: 1'b0, cyc: drv_cyc + 1});
        end
        gap(1);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (pl_q.size() != 0 && k < 3000) begin
            @(posedge clk);
            #1;
            valid_in = 1'b0;
            k++;
        end
        chk("drain_complete", 32'(pl_q.size()), 32'd0);
        gap(1);
    endtask

    initial begin
        logic [7:0] pq[$];
        logic [7:0] w;
        int         len;
        int         r;

        rst      = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_m_valid", 32'(m_valid), 32'd0);
        chk("reset_m_last", 32'(m_last), 32'd0);
        chk("reset_frame_ok", 32'(frame_ok), 32'd0);
        chk("reset_frame_err", 32'(frame_err), 32'd0);
        chk("reset_drop_cnt", 32'(drop_cnt), 32'd0);

        // Good frame, always ready: words on three consecutive cycles.
        rdy_mode = 0;
        pq = {8'h11, 8'h22, 8'h33};
        send_frame(3, pq, 2, 8'h03, 0);
        do @(negedge clk); while (cyc < last_chk_cyc + 2);
        #1;
        chk("stream_back_to_back_mid", 32'(pl_q.size()), 32'd1);
        do @(negedge clk); while (cyc < last_chk_cyc + 3);
        #1;
        chk("stream_back_to_back_end", 32'(pl_q.size()), 32'd0);
        wait_drain();

        // Bad checksum, then a one-word frame.
        pq = {8'h10, 8'h20};
        send_frame(2, pq, 2, 8'hFF, 0);
        gap(3);
        chk("bad_chk_no_output", 32'(m_valid), 32'd0);
        pq = {8'h7E};
        send_frame(1, pq, 2, 8'h7F, 0);
        wait_drain();

        // Illegal lengths.
        pq = {};
        send_frame(0, pq, 0, 8'h00, 0);
        send_frame(ML + 1, pq, 0, 8'h00, 0);
        gap(2);
        chk("bad_len_no_output", 32'(m_valid), 32'd0);

        // Backpressure with a random ready pattern.
        rdy_mode = 1;
        pq = {8'hC1, 8'hC2, 8'hC3};
        send_frame(3, pq, 0, 8'h00, 1);
        wait_drain();

        // Drops while stalled, then the final handshake cycle also drops a SOF.
        rdy_mode = 2;
        pq = {8'h5A};
        send_frame(1, pq, 0, 8'h00, 0);
        send_word(8'h01);
        send_word(8'h02);
        exp_drop = exp_drop + 2;
        gap(2);
        @(posedge clk);
        rdy_mode = 0;
        #1;
        valid_in = 1'b1;
        data_in  = SOF;
        exp_drop = exp_drop + 1;
        pq = {8'h44, 8'h55};
        send_frame(2, pq, 0, 8'h00, 0);
        wait_drain();
        chk("drop_cnt_small", 32'(drop_cnt), 32'(exp_drop));

        // Saturation of the drop counter.
        rdy_mode = 2;
        pq = {8'hD1, 8'hD2, 8'hD3};
        send_frame(3, pq, 0, 8'h00, 0);
        for (int i = 0; i < 300; i++) send_word(8'($urandom));
        exp_drop = (exp_drop + 300 > 255) ? 255 : exp_drop + 300;
        gap(2);
        chk("drop_cnt_saturated", 32'(drop_cnt), 32'(exp_drop));
        rdy_mode = 0;
        wait_drain();
        chk("idle_after_drain", 32'(m_valid), 32'd0);

        // Reset in the middle of a payload abandons the frame.
        send_word(SOF);
        send_word(8'h04);
        send_word(8'h01);
        send_word(8'h02);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_drop = 0;
        @(negedge clk);
        chk("midrst_m_valid", 32'(m_valid), 32'd0);
        chk("midrst_m_last", 32'(m_last), 32'd0);
        chk("midrst_frame_ok", 32'(frame_ok), 32'd0);
        chk("midrst_frame_err", 32'(frame_err), 32'd0);
        chk("midrst_drop_cnt", 32'(drop_cnt), 32'(exp_drop));
        pq = {8'h0A, 8'h0B, 8'h0C, 8'h0D};
        send_frame(4, pq, 0, 8'h00, 0);
        wait_drain();

        // Randomized frames with idle garbage, embedded SOF values and gaps.
        for (int f = 0; f < 40; f++) begin
            rdy_mode = $urandom_range(0, 1);
            repeat ($urandom_range(0, 3)) begin
                w = 8'($urandom);
                if (w == SOF) w = 8'h00;
                send_word(w);
            end
            gap($urandom_range(0, 2));
            r = $urandom_range(0, 9);
            if (r == 0) len = 0;
            else if (r == 1) len = $urandom_range(ML + 1, 255);
            else len = $urandom_range(1, ML);
            pq = {};
            if (len <= ML) begin
                for (int k = 0; k < len; k++) begin
                    w = 8'($urandom);
                    if ($urandom_range(0, 5) == 0) w = SOF;
                    pq.push_back(w);
                end
            end
            send_frame(len, pq, ($urandom_range(0, 3) == 0) ? 1 : 0, 8'h00, 2);
            wait_drain();
        end
        gap(3);
        chk("drop_cnt_final", 32'(drop_cnt), 32'(exp_drop));
        chk("events_left", 32'(ev_q.size()), 32'd0);
        chk("words_left", 32'(pl_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
